ps2_keycode_rx: RTL and testbench

PS/2 keyboard receiver that produces the held-key `keycode` consumed by the sprite/motion controller. It deserialises 11-bit PS/2 device-to-host frames and tracks make, break and extended prefixes. It presents the currently held key's scan code, or 0x00 when no key is held. It sits between the board's PS/2 pins and every game block that reads `keycode`.

---
 rtl/ps2_pkg.sv | 36 +++
 rtl/ps2_keycode_rx_if.sv | 20 ++
 rtl/ps2_frame_rx.sv | 122 ++++++++++++
 rtl/ps2_keycode_rx.sv | 80 ++++++++
 tb/tb_ps2_keycode_rx.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keycode receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } frame_state_t;

   localparam logic [7:0] KEY_UP     = 8'h75;
   localparam logic [7:0] KEY_DOWN   = 8'h72;
   localparam logic [7:0] KEY_LEFT   = 8'h6B;
   localparam logic [7:0] KEY_RIGHT  = 8'h74;
   localparam logic [7:0] PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PREFIX_BRK = 8'hF0;

   localparam logic [7:0] IGN_BAT_OK = 8'hAA;
   localparam logic [7:0] IGN_ACK    = 8'hFA;
   localparam logic [7:0] IGN_ECHO   = 8'hEE;
   localparam logic [7:0] IGN_RESEND = 8'hFE;
   localparam logic [7:0] IGN_ERR0   = 8'h00;
   localparam logic [7:0] IGN_ERR1   = 8'hFF;
   localparam logic [7:0] IGN_PAUSE  = 8'hE1;

   function automatic logic is_ignored(input logic [7:0] b);
      logic r;
      case (b)
         IGN_BAT_OK, IGN_ACK, IGN_ECHO, IGN_RESEND,
         IGN_ERR0, IGN_ERR1, IGN_PAUSE: r = 1'b1;
         default:                       r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// PS/2 pins and decoded key outputs; slave = receiver, master = pin driver / consumer.
interface ps2_keycode_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keycode;
   logic       key_ext;
   logic [7:0] scan_byte;
   logic       byte_valid;
   logic       frame_err;

   modport slave (
      input  ps2_clk, ps2_data,
      output keycode, key_ext, scan_byte, byte_valid, frame_err
   );

   modport master (
      output ps2_clk, ps2_data,
      input  keycode, key_ext, scan_byte, byte_valid, frame_err
   );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: synchronisers, clock glitch filter, frame FSM, timeout.
// o_byte_ok / o_err are single-cycle strobes in the stop-bit (or timeout) cycle.
//   state  | meaning
//   IDLE   | waiting for a start bit (data=0 on a falling edge)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking stop bit and parity, then back to IDLE
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic [7:0] o_byte,
   output logic       o_byte_ok,
   output logic       o_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]   r_clk_sync;
   logic [1:0]   r_dat_sync;
   logic         r_filt;
   logic [FW-1:0] r_fcnt;
   frame_state_t r_state;
   frame_state_t w_next;
   logic [2:0]   r_bit_cnt;
   logic [7:0]   r_shift;
   logic         r_parity;
   logic [TW-1:0] r_tcnt;

   logic w_fall;
   logic w_data;
   logic w_timeout;

   // The edge is the cycle the filter commits a 1->0 change.
   assign w_fall    = r_filt & ~r_clk_sync[1] & (r_fcnt == FW'(FILTER_LEN - 1));
   assign w_data    = r_dat_sync[1];
   assign w_timeout = (r_state != IDLE) && (r_tcnt == TW'(TIMEOUT_CYCLES));
   assign o_byte    = r_shift;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_sync <= 2'b11;
         r_dat_sync <= 2'b11;
         r_filt     <= 1'b1;
         r_fcnt     <= '0;
      end else begin
         r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
         r_dat_sync <= {r_dat_sync[0], i_ps2_data};
         if (r_clk_sync[1] != r_filt) begin
            if (r_fcnt == FW'(FILTER_LEN - 1)) begin
               r_filt <= r_clk_sync[1];
               r_fcnt <= '0;
            end else begin
               r_fcnt <= r_fcnt + 1'b1;
            end
         end else begin
            r_fcnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      o_byte_ok = 1'b0;
      o_err     = 1'b0;
      if (w_timeout) begin
         w_next = IDLE;
         o_err  = 1'b1;
      end else if (w_fall) begin
         case (r_state)
            IDLE:   if (!w_data) w_next = DATA;
            DATA:   if (r_bit_cnt == 3'd7) w_next = PARITY;
            PARITY: w_next = STOP;
            STOP: begin
               w_next = IDLE;
               if (w_data && (^{r_shift, r_parity})) o_byte_ok = 1'b1;
               else                                  o_err     = 1'b1;
            end
            default: w_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_tcnt    <= '0;
      end else begin
         if (r_state == IDLE || w_fall || w_timeout) r_tcnt <= '0;
         else                                        r_tcnt <= r_tcnt + 1'b1;
         if (w_fall && !w_timeout) begin
            case (r_state)
               IDLE:   r_bit_cnt <= '0;
               DATA: begin
                  r_shift   <= {w_data, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
               PARITY: r_parity <= w_data;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver top: frame deserialiser plus make/break decoder tracking one held key.
module ps2_keycode_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic           clk,
   input  logic           rst_n,
   ps2_keycode_rx_if.slave bus
);

   logic [7:0] w_byte;
   logic       w_byte_ok;
   logic       w_err;

   logic [7:0] r_keycode;
   logic       r_key_ext;
   logic [7:0] r_scan_byte;
   logic       r_byte_valid;
   logic       r_frame_err;
   logic       r_ext;
   logic       r_brk;

   ps2_frame_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frame (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_ps2_clk  (bus.ps2_clk),
      .i_ps2_data (bus.ps2_data),
      .o_byte     (w_byte),
      .o_byte_ok  (w_byte_ok),
      .o_err      (w_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_keycode    <= '0;
         r_key_ext    <= 1'b0;
         r_scan_byte  <= '0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_ext        <= 1'b0;
         r_brk        <= 1'b0;
      end else begin
         r_byte_valid <= w_byte_ok;
         r_frame_err  <= w_err;
         if (w_byte_ok) begin
            r_scan_byte <= w_byte;
            if (w_byte == PREFIX_EXT) begin
               r_ext <= 1'b1;
            end else if (w_byte == PREFIX_BRK) begin
               r_brk <= 1'b1;
            end else begin
               r_ext <= 1'b0;
               r_brk <= 1'b0;
               if (!is_ignored(w_byte)) begin
                  if (!r_brk) begin
                     r_keycode <= w_byte;
                     r_key_ext <= r_ext;
                  end else if (w_byte == r_keycode && r_ext == r_key_ext) begin
                     // Releases of a key other than the held one fall through untouched.
                     r_keycode <= '0;
                     r_key_ext <= 1'b0;
                  end
               end
            end
         end
      end
   end

   assign bus.keycode    = r_keycode;
   assign bus.key_ext    = r_key_ext;
   assign bus.scan_byte  = r_scan_byte;
   assign bus.byte_valid = r_byte_valid;
   assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: table of frames with expected held key, scoreboard on byte_valid,
// plus timeout, glitch and mid-frame reset sequences.
module tb_ps2_keycode_rx;

   localparam int FILT = 8;
   localparam int TOUT = 1000;
   localparam int HP   = 20;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   int   n_valid;
   int   n_err;

   ps2_keycode_rx_if u_if ();

   ps2_keycode_rx #(
      .FILTER_LEN     (FILT),
      .TIMEOUT_CYCLES (TOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      bit         bad_par;
      bit         bad_stop;
      logic [7:0] exp_kc;
      bit         exp_ext;
   } vec_t;

   typedef struct {
      logic [7:0] sb;
      logic [7:0] kc;
      bit         ext;
   } exp_t;

   vec_t vecs[$];
   exp_t sbq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   function automatic void add(input logic [7:0] d, input bit bp, input bit bs,
                               input logic [7:0] kc, input bit ext);
      vec_t v;
      v.data = d; v.bad_par = bp; v.bad_stop = bs; v.exp_kc = kc; v.exp_ext = ext;
      vecs.push_back(v);
   endfunction

   function automatic void expect_byte(input logic [7:0] sb, input logic [7:0] kc, input bit ext);
      exp_t e;
      e.sb = sb; e.kc = kc; e.ext = ext;
      sbq.push_back(e);
   endfunction

   // Drives the first n bits of an 11-bit frame; optional short low glitch in each high phase.
   task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
      for (int i = 0; i < n; i++) begin
         u_if.ps2_data = bits[i];
         if (glitch) begin
            cyc(4);
            u_if.ps2_clk = 1'b0;
            cyc(FILT - 3);
            u_if.ps2_clk = 1'b1;
            cyc(HP - FILT - 1);
         end else begin
            cyc(HP);
         end
         u_if.ps2_clk = 1'b0;
         cyc(HP);
         u_if.ps2_clk = 1'b1;
      end
      cyc(HP);
      u_if.ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                             input bit glitch);
      logic par;
      logic [10:0] bits;
      par  = ~(^d) ^ bad_par;
      bits = {~bad_stop, par, d, 1'b0};
      send_bits(bits, 11, glitch);
      cyc(3 * HP);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (u_if.frame_err) n_err++;
         if (u_if.byte_valid) begin
            n_valid++;
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_byte: got %0h expected none", u_if.scan_byte);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("sb_scan_byte", {24'd0, u_if.scan_byte}, {24'd0, e.sb});
               chk("sb_keycode",   {24'd0, u_if.keycode},   {24'd0, e.kc});
               chk("sb_key_ext",   {31'd0, u_if.key_ext},   {31'd0, e.ext});
            end
         end
      end
   end

   initial begin
      int e0;
      int v0;
      tests = 0; fails = 0; n_valid = 0; n_err = 0;
      rst_n = 1'b0;
      u_if.ps2_clk  = 1'b1;
      u_if.ps2_data = 1'b1;

      add(8'hE0, 0, 0, 8'h00, 0);
      add(8'h75, 0, 0, 8'h75, 1);
      add(8'hE0, 0, 0, 8'h75, 1);
      add(8'hF0, 0, 0, 8'h75, 1);
      add(8'h74, 0, 0, 8'h75, 1);
      add(8'hE0, 0, 0, 8'h75, 1);
      add(8'hF0, 0, 0, 8'h75, 1);
      add(8'h75, 0, 0, 8'h00, 0);
      add(8'h75, 0, 0, 8'h75, 0);
      add(8'hE0, 0, 0, 8'h75, 0);
      add(8'h6B, 0, 0, 8'h6B, 1);
      for (int k = 0; k < 5; k++) begin
         add(8'hE0, 0, 0, 8'h6B, 1);
         add(8'h6B, 0, 0, 8'h6B, 1);
      end
      add(8'hF0, 0, 0, 8'h6B, 1);
      add(8'h6B, 0, 0, 8'h6B, 1);
      add(8'h75, 1, 0, 8'h6B, 1);
      add(8'h75, 0, 1, 8'h6B, 1);
      add(8'hAA, 0, 0, 8'h6B, 1);
      add(8'hFA, 0, 0, 8'h6B, 1);
      add(8'hE0, 0, 0, 8'h6B, 1);
      add(8'hAA, 0, 0, 8'h6B, 1);
      add(8'h1C, 0, 0, 8'h1C, 0);
      add(8'hF0, 0, 0, 8'h1C, 0);
      add(8'h1C, 0, 0, 8'h00, 0);

      cyc(5);
      @(negedge clk);
      chk("rst_keycode",    {24'd0, u_if.keycode},   32'h00);
      chk("rst_key_ext",    {31'd0, u_if.key_ext},   32'h0);
      chk("rst_scan_byte",  {24'd0, u_if.scan_byte}, 32'h00);
      chk("rst_byte_valid", {31'd0, u_if.byte_valid}, 32'h0);
      chk("rst_frame_err",  {31'd0, u_if.frame_err}, 32'h0);
      rst_n = 1'b1;
      cyc(10);

      foreach (vecs[i]) begin
         e0 = n_err;
         v0 = n_valid;
         if (!vecs[i].bad_par && !vecs[i].bad_stop)
            expect_byte(vecs[i].data, vecs[i].exp_kc, vecs[i].exp_ext);
         send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 1'b0);
         @(negedge clk);
         if (vecs[i].bad_par || vecs[i].bad_stop) begin
            chk("bad_frame_err",   n_err - e0,   32'd1);
            chk("bad_frame_valid", n_valid - v0, 32'd0);
         end else begin
            chk("vec_valid", n_valid - v0, 32'd1);
            chk("vec_err",   n_err - e0,   32'd0);
         end
         chk("vec_keycode", {24'd0, u_if.keycode}, {24'd0, vecs[i].exp_kc});
         chk("vec_key_ext", {31'd0, u_if.key_ext}, {31'd0, vecs[i].exp_ext});
      end

      // Truncated frame: start + 3 data bits, then silence past the timeout.
      e0 = n_err;
      v0 = n_valid;
      send_bits(11'b111_1010_1010, 4, 1'b0);
      cyc(TOUT + 100);
      @(negedge clk);
      chk("timeout_err",   n_err - e0,   32'd1);
      chk("timeout_valid", n_valid - v0, 32'd0);
      expect_byte(8'h1C, 8'h1C, 0);
      send_frame(8'h1C, 0, 0, 1'b0);
      @(negedge clk);
      chk("after_timeout_kc", {24'd0, u_if.keycode}, 32'h1C);

      // Short ps2_clk glitches, idle with data low, then a glitched frame.
      e0 = n_err;
      v0 = n_valid;
      u_if.ps2_data = 1'b0;
      for (int g = 0; g < 6; g++) begin
         u_if.ps2_clk = 1'b0;
         cyc(FILT - 3);
         u_if.ps2_clk = 1'b1;
         cyc(12);
      end
      u_if.ps2_data = 1'b1;
      cyc(2 * HP);
      expect_byte(8'h74, 8'h74, 0);
      send_frame(8'h74, 0, 0, 1'b1);
      @(negedge clk);
      chk("glitch_valid",   n_valid - v0, 32'd1);
      chk("glitch_err",     n_err - e0,   32'd0);
      chk("glitch_keycode", {24'd0, u_if.keycode}, 32'h74);

      // Reset in the middle of a frame.
      send_bits(11'b111_0111_0110, 5, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_keycode",   {24'd0, u_if.keycode},   32'h00);
      chk("midrst_scan_byte", {24'd0, u_if.scan_byte}, 32'h00);
      chk("midrst_key_ext",   {31'd0, u_if.key_ext},   32'h0);
      chk("midrst_valid",     {31'd0, u_if.byte_valid}, 32'h0);
      chk("midrst_err",       {31'd0, u_if.frame_err}, 32'h0);
      u_if.ps2_clk  = 1'b1;
      u_if.ps2_data = 1'b1;
      cyc(5);
      rst_n = 1'b1;
      cyc(10);
      expect_byte(8'h72, 8'h72, 0);
      send_frame(8'h72, 0, 0, 1'b0);
      @(negedge clk);
      chk("post_rst_keycode", {24'd0, u_if.keycode}, 32'h72);

      cyc(20);
      chk("scoreboard_empty", sbq.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
